mux_rr_arbiter: RTL

Round-robin arbiter and sequencer that shares the 8:1 bit multiplexer among eight requesters. It owns the mux `sel` bus and grants exactly one requester at a time. Each grant is held for the requester's burst, then ownership rotates. A one-cycle dead gap is inserted between owners so the mux output never switches mid-grant. It sits directly in front of the 8:1 mux; `sel` drives the mux select and `gnt` goes back to the requesters.

---
 rtl/mux_rr_arbiter_if.sv | 13 +
 rtl/mux_rr_arbiter.sv | 104 ++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter_if.sv
// Request/grant bundle between the eight requesters, the round-robin arbiter
// and the 8:1 mux select. Requesters use the master modport; the arbiter uses slave.
interface mux_rr_arbiter_if;
  logic [7:0] req;
  logic       done;
  logic [2:0] sel;
  logic [7:0] gnt;
  logic       valid;
  logic       timeout;

  modport master (output req, done, input sel, gnt, valid, timeout);
  modport slave  (input req, done, output sel, gnt, valid, timeout);
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter owning the 8:1 mux select, with a one-cycle dead gap between owners.
// Define ARB_TIMEOUT_EN to preempt an owner after MAX_HOLD consecutive grant cycles.
module mux_rr_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input  logic              clk,
  input  logic              rst,
  mux_rr_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t     state;
  logic [2:0] ptr;
  logic [2:0] sel;
  logic [7:0] gnt;
  logic       valid;
  logic [2:0] winner;
  logic       any_req;
  logic       at_limit;
  logic       rel;

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("mux_rr_arbiter: MAX_HOLD must be in 2..255");
  end

  // Downward scan so the requester closest to ptr (mod 8) is the last writer.
  always_comb begin
    winner  = ptr;
    any_req = |bus.req;
    for (int i = 7; i >= 0; i--) begin
      if (bus.req[ptr + 3'(i)]) winner = ptr + 3'(i);
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] hold_cnt;
  logic       timeout_q;

  assign at_limit    = (hold_cnt == HOLD_LAST);
  assign bus.timeout = timeout_q;
`else
  assign at_limit    = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  assign rel = !bus.req[sel] || bus.done || at_limit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= 3'd0;
      sel   <= 3'd0;
      gnt   <= 8'd0;
      valid <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_cnt  <= 8'd0;
      timeout_q <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state)
        IDLE, GAP: begin
          if (any_req) begin
            sel   <= winner;
            gnt   <= 8'd1 << winner;
            valid <= 1'b1;
            state <= GRANT;
`ifdef ARB_TIMEOUT_EN
            hold_cnt <= 8'd0;
`endif
          end else begin
            state <= IDLE;
          end
        end
        GRANT: begin
          // sel is kept through the gap so the mux output stays on the old owner.
          if (rel) begin
            gnt   <= 8'd0;
            valid <= 1'b0;
            ptr   <= sel + 3'd1;
            state <= GAP;
`ifdef ARB_TIMEOUT_EN
            timeout_q <= at_limit && bus.req[sel] && !bus.done;
`endif
          end else begin
`ifdef ARB_TIMEOUT_EN
            hold_cnt <= hold_cnt + 8'd1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sel   = sel;
  assign bus.gnt   = gnt;
  assign bus.valid = valid;

endmodule
